pc_sequencer: RTL and testbench

Next-PC controller for the dual-issue program counter of the OOO-OTTER front end. Each cycle it picks the next fetch address pair from sequential advance, decode jumps, branch-mispredict recovery and traps, then drives the PC register's load/data inputs. It holds redirects that arrive while instruction memory is busy, and tags fetch bundles with a redirect epoch so stale responses can be squashed downstream.

---
 rtl/pcs_pkg.sv | 21 ++
 rtl/pcs_redirect_arb.sv | 40 ++++
 rtl/pc_sequencer.sv | 155 +++++++++++++++
 tb/tb_pc_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared types and constants for the next-PC sequencer of the dual-issue front end.
package pcs_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } pcs_state_t;

    // The numeric value doubles as the redirect priority, so sources compare with >=.
    typedef enum logic [1:0] {
        SRC_NONE    = 2'd0,
        SRC_JUMP    = 2'd1,
        SRC_MISPRED = 2'd2,
        SRC_TRAP    = 2'd3
    } redir_src_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned ISSUE_W     = 2;

endpackage

// File: rtl/pcs_redirect_arb.sv
// Combinational redirect arbiter: trap beats mispredict beats jump; the winner's
// target is word-aligned and its dropped low bits are reported as misalign.
module pcs_redirect_arb
    import pcs_pkg::*;
(
    input  logic        trap_i,
    input  logic [31:0] trap_vec_i,
    input  logic        mispred_i,
    input  logic [31:0] mispred_pc_i,
    input  logic        jump_i,
    input  logic [31:0] jump_pc_i,
    output logic        valid_o,
    output redir_src_t  src_o,
    output logic [31:0] target_o,
    output logic        misalign_o
);

    logic [31:0] raw_target;

    always_comb begin
        valid_o    = 1'b1;
        src_o      = SRC_NONE;
        raw_target = 32'h0;
        if (trap_i) begin
            src_o      = SRC_TRAP;
            raw_target = trap_vec_i;
        end else if (mispred_i) begin
            src_o      = SRC_MISPRED;
            raw_target = mispred_pc_i;
        end else if (jump_i) begin
            src_o      = SRC_JUMP;
            raw_target = jump_pc_i;
        end else begin
            valid_o = 1'b0;
        end
        target_o   = {raw_target[31:2], 2'b00};
        misalign_o = valid_o && (raw_target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: chooses sequential advance or a redirect each cycle, parks
// redirects while imem is busy, and bumps a redirect epoch on every flush.
module pc_sequencer
    import pcs_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        PCS_CLK,
    input  logic        PCS_RST,
    input  logic [31:0] PCS_CUR_PC0,
    input  logic        PCS_TRAP,
    input  logic [31:0] PCS_TRAP_VEC,
    input  logic        PCS_MISPRED,
    input  logic [31:0] PCS_MISPRED_PC,
    input  logic        PCS_JUMP,
    input  logic [31:0] PCS_JUMP_PC,
    input  logic        PCS_FETCH_RDY,
    input  logic [1:0]  PCS_ISSUE_CNT,
    output logic        PCS_LD,
    output logic [31:0] PCS_DIN0,
    output logic [31:0] PCS_DIN1,
    output logic        PCS_FETCH_VALID,
    output logic        PCS_FLUSH,
    output logic [1:0]  PCS_EPOCH,
    output logic        PCS_MISALIGN
);

    pcs_state_t  state_q, state_d;
    logic [31:0] pend_q, pend_d;
    redir_src_t  pend_src_q, pend_src_d;
    logic [1:0]  epoch_q, epoch_d;

    logic        arb_valid;
    redir_src_t  arb_src;
    logic [31:0] arb_target;
    logic        arb_misalign;

    logic [1:0]  issue_eff;
    logic [31:0] seq_pc;
    logic        ld;
    logic [31:0] din0;
    logic        fetch_valid;
    logic        flush;
    logic        misalign;

    pcs_redirect_arb u_arb (
        .trap_i      (PCS_TRAP),
        .trap_vec_i  (PCS_TRAP_VEC),
        .mispred_i   (PCS_MISPRED),
        .mispred_pc_i(PCS_MISPRED_PC),
        .jump_i      (PCS_JUMP),
        .jump_pc_i   (PCS_JUMP_PC),
        .valid_o     (arb_valid),
        .src_o       (arb_src),
        .target_o    (arb_target),
        .misalign_o  (arb_misalign)
    );

    // An issue count of 3 cannot occur on a two-wide bundle; clamp it to the width.
    assign issue_eff = (PCS_ISSUE_CNT > 2'(ISSUE_W)) ? 2'(ISSUE_W) : PCS_ISSUE_CNT;
    assign seq_pc    = PCS_CUR_PC0 + 32'(issue_eff) * 32'(INSTR_BYTES);

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_src_d  = pend_src_q;
        epoch_d     = epoch_q;
        ld          = 1'b0;
        din0        = RESET_VEC;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        misalign    = 1'b0;

        if (PCS_RST) begin
            state_d    = BOOT;
            pend_d     = 32'h0;
            pend_src_d = SRC_NONE;
            epoch_d    = 2'd0;
        end else begin
            unique case (state_q)
                BOOT: begin
                    ld      = 1'b1;
                    din0    = RESET_VEC;
                    state_d = RUN;
                end
                RUN: begin
                    if (arb_valid) begin
                        flush    = 1'b1;
                        misalign = arb_misalign;
                        epoch_d  = epoch_q + 2'd1;
                        din0     = arb_target;
                        if (PCS_FETCH_RDY) begin
                            ld = 1'b1;
                        end else begin
                            pend_d     = arb_target;
                            pend_src_d = arb_src;
                            state_d    = HOLD;
                        end
                    end else begin
                        fetch_valid = 1'b1;
                        din0        = seq_pc;
                        ld          = PCS_FETCH_RDY && (issue_eff != 2'd0);
                    end
                end
                HOLD: begin
                    din0 = pend_q;
                    if (arb_valid && (arb_src >= pend_src_q)) begin
                        flush    = 1'b1;
                        misalign = arb_misalign;
                        epoch_d  = epoch_q + 2'd1;
                        din0     = arb_target;
                        if (PCS_FETCH_RDY) begin
                            ld         = 1'b1;
                            pend_src_d = SRC_NONE;
                            state_d    = RUN;
                        end else begin
                            pend_d     = arb_target;
                            pend_src_d = arb_src;
                        end
                    end else if (PCS_FETCH_RDY) begin
                        ld         = 1'b1;
                        pend_src_d = SRC_NONE;
                        state_d    = RUN;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge PCS_CLK) begin
        if (PCS_RST) begin
            state_q    <= BOOT;
            pend_q     <= 32'h0;
            pend_src_q <= SRC_NONE;
            epoch_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_src_q <= pend_src_d;
            epoch_q    <= epoch_d;
        end
    end

    assign PCS_LD          = ld;
    assign PCS_DIN0        = din0;
    assign PCS_DIN1        = din0 + 32'(INSTR_BYTES);
    assign PCS_FETCH_VALID = fetch_valid;
    assign PCS_FLUSH       = flush;
    assign PCS_EPOCH       = PCS_RST ? 2'd0 : epoch_q;
    assign PCS_MISALIGN    = misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed walk through the redirect scenarios, then random
// traffic, all checked against a redirect-level reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cur_pc;
    logic        trap;
    logic [31:0] trap_vec;
    logic        mispred;
    logic [31:0] mispred_pc;
    logic        jump;
    logic [31:0] jump_pc;
    logic        rdy;
    logic [1:0]  cnt;
    logic        ld;
    logic [31:0] din0;
    logic [31:0] din1;
    logic        fetch_valid;
    logic        flush;
    logic [1:0]  epoch;
    logic        misalign;

    int tests = 0;
    int fails = 0;

    // Reference model: booting flag, optional parked redirect with its priority, epoch.
    bit          m_boot = 1'b1;
    bit          m_pend_vld = 1'b0;
    logic [31:0] m_pend_addr = 32'h0;
    int          m_pend_pri = 0;
    int          m_epoch = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_VEC(RV)
    ) dut (
        .PCS_CLK        (clk),
        .PCS_RST        (rst),
        .PCS_CUR_PC0    (cur_pc),
        .PCS_TRAP       (trap),
        .PCS_TRAP_VEC   (trap_vec),
        .PCS_MISPRED    (mispred),
        .PCS_MISPRED_PC (mispred_pc),
        .PCS_JUMP       (jump),
        .PCS_JUMP_PC    (jump_pc),
        .PCS_FETCH_RDY  (rdy),
        .PCS_ISSUE_CNT  (cnt),
        .PCS_LD         (ld),
        .PCS_DIN0       (din0),
        .PCS_DIN1       (din1),
        .PCS_FETCH_VALID(fetch_valid),
        .PCS_FLUSH      (flush),
        .PCS_EPOCH      (epoch),
        .PCS_MISALIGN   (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit t, input logic [31:0] tv, input bit m,
                         input logic [31:0] mp, input bit j, input logic [31:0] jp,
                         input bit rd, input logic [1:0] c, input logic [31:0] pc);
        rst = r; trap = t; trap_vec = tv; mispred = m; mispred_pc = mp;
        jump = j; jump_pc = jp; rdy = rd; cnt = c; cur_pc = pc;
    endtask

    // Check this cycle's outputs against the model, optionally against a plan value
    // for DIN0, then advance the model across the clock edge.
    task automatic step(input string name, input bit use_want, input logic [31:0] want);
        int          pri;
        int          n;
        logic [31:0] raw;
        bit          e_ld, e_fv, e_fl, e_mis, e_din_chk;
        logic [31:0] e_din;

        #1;
        pri = trap ? 3 : mispred ? 2 : jump ? 1 : 0;
        raw = trap ? trap_vec : mispred ? mispred_pc : jump_pc;
        e_ld = 0; e_fv = 0; e_fl = 0; e_mis = 0; e_din_chk = 1; e_din = RV;

        if (rst) begin
            chk({name, "/epoch"}, 32'(epoch), 32'd0);
        end else begin
            chk({name, "/epoch"}, 32'(epoch), 32'(m_epoch));
        end

        if (rst) begin
            m_boot = 1; m_pend_vld = 0; m_epoch = 0;
        end else if (m_boot) begin
            e_ld = 1;
            m_boot = 0;
        end else if (pri > 0 && (!m_pend_vld || pri >= m_pend_pri)) begin
            e_fl = 1;
            e_mis = (raw[1:0] != 2'b00);
            m_epoch = (m_epoch + 1) % 4;
            if (rdy) begin
                e_ld = 1;
                e_din = raw & 32'hFFFF_FFFC;
                m_pend_vld = 0;
            end else begin
                e_din_chk = 0;
                m_pend_vld = 1;
                m_pend_addr = raw & 32'hFFFF_FFFC;
                m_pend_pri = pri;
            end
        end else if (m_pend_vld) begin
            if (rdy) begin
                e_ld = 1;
                e_din = m_pend_addr;
                m_pend_vld = 0;
            end else begin
                e_din_chk = 0;
            end
        end else begin
            n = (cnt > 2) ? 2 : int'(cnt);
            e_fv = 1;
            e_din = cur_pc + 32'(4 * n);
            e_ld = rdy && (n != 0);
        end

        chk({name, "/ld"}, 32'(ld), 32'(e_ld));
        chk({name, "/fetch_valid"}, 32'(fetch_valid), 32'(e_fv));
        chk({name, "/flush"}, 32'(flush), 32'(e_fl));
        chk({name, "/misalign"}, 32'(misalign), 32'(e_mis));
        if (e_din_chk) begin
            chk({name, "/din0"}, din0, e_din);
            chk({name, "/din1"}, din1, e_din + 32'd4);
        end
        if (use_want) begin
            chk({name, "/plan_din0"}, din0, want);
        end
        @(negedge clk);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step("reset", 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h100);
        step("boot", 1, 32'h100);

        drive(0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 32'h100);
        step("seq2", 1, 32'h108);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 32'h100);
        step("seq1", 1, 32'h104);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 32'h100);
        step("seq0", 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 32'h100);
        step("seq_busy", 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2'd3, 32'h100);
        step("seq3_clamp", 1, 32'h108);

        drive(0, 1, 32'h80, 1, 32'h200, 1, 32'h300, 1, 2'd2, 32'h100);
        step("prio_all", 1, 32'h80);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 32'h80);
        step("prio_after", 0, 0);

        drive(0, 0, 0, 1, 32'h200, 0, 0, 0, 2'd0, 32'h80);
        step("hold_enter", 0, 0);
        drive(0, 1, 32'h80, 0, 0, 0, 0, 0, 2'd0, 32'h80);
        step("hold_trap_ovr", 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h300, 0, 2'd0, 32'h80);
        step("hold_jump_low", 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 32'h80);
        step("hold_release", 1, 32'h80);

        drive(0, 0, 0, 0, 0, 1, 32'h102, 1, 2'd0, 32'h80);
        step("misalign", 1, 32'h100);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 1, 32'h400 + 32'(16 * i), 1, 2'd0, 32'h100);
            step("epoch_wrap", 1, 32'h400 + 32'(16 * i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 32'h430);
        step("epoch_wrapped", 1, 32'h434);

        drive(0, 0, 0, 1, 32'h200, 0, 0, 0, 2'd0, 32'h434);
        step("rsthold_enter", 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 32'h434);
        step("rsthold_rst", 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 32'h434);
        step("rsthold_boot", 1, 32'h100);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 32'h100);
        step("rsthold_run", 1, 32'h108);

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 7) == 0), $urandom,
                  ($urandom_range(0, 5) == 0), $urandom,
                  ($urandom_range(0, 4) == 0), $urandom,
                  ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom);
            step("rand", 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
